// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched word, drives the register file
// read ports in the accept cycle, and tracks in-flight destination registers
// in a 32-entry scoreboard to stall on RAW/WAW hazards.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. On the fetch side, if_ready is combinational and never depends
// on if_valid. On the execute side, id_valid stays high and every id_* output
// holds stable until id_ready is seen high.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  output logic [4:0]  rf_addr1,
  output logic [4:0]  rf_addr2,
  output logic        rf_rd1,
  output logic        rf_rd2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [31:0] id_imm,
  output logic        id_uses_rs1,
  output logic        id_uses_rs2,
  output logic        id_writes_rd,
  output logic        id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic        w_uses_rs1, w_uses_rs2, w_wr_any, w_illegal, w_writes_rd;
  logic [31:0] w_clr;
  logic        w_hazard, w_accept;
  logic [31:0] w_busy_nxt;

  logic [31:0] r_busy;
  logic        r_id_valid;
  logic [31:0] r_id_pc, r_id_imm;
  logic [6:0]  r_id_opcode;
  logic [2:0]  r_id_funct3;
  logic        r_id_funct7b5;
  logic [4:0]  r_id_rd, r_id_rs1, r_id_rs2;
  logic        r_id_uses_rs1, r_id_uses_rs2, r_id_writes_rd, r_id_illegal;

  assign w_opcode = if_instr[6:0];
  assign w_funct3 = if_instr[14:12];
  assign w_rd     = if_instr[11:7];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];

  assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign w_imm_b = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign w_imm_u = {if_instr[31:12], 12'b0};
  assign w_imm_j = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Opcode/funct3 legality, immediate format select and operand usage flags.
  always_comb begin
    w_imm      = '0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_wr_any   = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_imm    = w_imm_u;
        w_wr_any = 1'b1;
      end
      OPC_JAL: begin
        w_imm    = w_imm_j;
        w_wr_any = 1'b1;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_imm      = w_imm_i;
          w_uses_rs1 = 1'b1;
          w_wr_any   = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
          w_imm      = w_imm_b;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            w_imm      = w_imm_i;
            w_uses_rs1 = 1'b1;
            w_wr_any   = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        if (w_funct3 <= 3'b010) begin
          w_imm      = w_imm_s;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_imm      = w_imm_i;
        w_uses_rs1 = 1'b1;
        w_wr_any   = 1'b1;
      end
      OPC_OP: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_wr_any   = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_writes_rd = w_wr_any && (w_rd != 5'd0);

  // A retiring write releases its register in the same cycle (the register
  // file forwards the data), so cleared bits do not count toward a hazard.
  assign w_clr    = (wb_valid && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;
  assign w_hazard = (w_uses_rs1  && r_busy[w_rs1] && !w_clr[w_rs1]) ||
                    (w_uses_rs2  && r_busy[w_rs2] && !w_clr[w_rs2]) ||
                    (w_writes_rd && r_busy[w_rd]  && !w_clr[w_rd]);

  assign if_ready = rst_n && !flush && !w_hazard && (!r_id_valid || id_ready);
  assign w_accept = if_valid && if_ready;

  assign rf_addr1 = w_rs1;
  assign rf_addr2 = w_rs2;
  assign rf_rd1   = w_accept && w_uses_rs1;
  assign rf_rd2   = w_accept && w_uses_rs2;

  // Next scoreboard: clear on writeback or flush of the held writer, then set
  // for a newly accepted writer so a set beats a same-cycle clear.
  always_comb begin
    w_busy_nxt = r_busy & ~w_clr;
    if (flush && r_id_valid && r_id_writes_rd) w_busy_nxt[r_id_rd] = 1'b0;
    if (w_accept && w_writes_rd) w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard and ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy         <= '0;
      r_id_valid     <= 1'b0;
      r_id_pc        <= '0;
      r_id_imm       <= '0;
      r_id_opcode    <= '0;
      r_id_funct3    <= '0;
      r_id_funct7b5  <= 1'b0;
      r_id_rd        <= '0;
      r_id_rs1       <= '0;
      r_id_rs2       <= '0;
      r_id_uses_rs1  <= 1'b0;
      r_id_uses_rs2  <= 1'b0;
      r_id_writes_rd <= 1'b0;
      r_id_illegal   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_id_valid <= 1'b0;
      end else if (w_accept) begin
        r_id_valid     <= 1'b1;
        r_id_pc        <= if_pc;
        r_id_imm       <= w_imm;
        r_id_opcode    <= w_opcode;
        r_id_funct3    <= w_funct3;
        r_id_funct7b5  <= if_instr[30];
        r_id_rd        <= w_rd;
        r_id_rs1       <= w_rs1;
        r_id_rs2       <= w_rs2;
        r_id_uses_rs1  <= w_uses_rs1;
        r_id_uses_rs2  <= w_uses_rs2;
        r_id_writes_rd <= w_writes_rd;
        r_id_illegal   <= w_illegal;
      end else if (r_id_valid && id_ready) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign id_valid     = r_id_valid;
  assign id_pc        = r_id_pc;
  assign id_opcode    = r_id_opcode;
  assign id_funct3    = r_id_funct3;
  assign id_funct7b5  = r_id_funct7b5;
  assign id_rd        = r_id_rd;
  assign id_rs1       = r_id_rs1;
  assign id_rs2       = r_id_rs2;
  assign id_imm       = r_id_imm;
  assign id_uses_rs1  = r_id_uses_rs1;
  assign id_uses_rs2  = r_id_uses_rs2;
  assign id_writes_rd = r_id_writes_rd;
  assign id_illegal   = r_id_illegal;

endmodule
